// File: rtl/multicycle_muldiv_unit_pkg.sv
// Shared types for the iterative M-extension unit: op codes, FSM states and
// request/response records.
package multicycle_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  // Records are sized for the widest configuration (RV64, 8-bit tag).
  localparam int MAX_XLEN  = 64;
  localparam int MAX_TAG_W = 8;

  typedef struct packed {
    muldiv_op_e           op;
    logic [MAX_XLEN-1:0]  rs1;
    logic [MAX_XLEN-1:0]  rs2;
    logic [MAX_TAG_W-1:0] tag;
  } muldiv_req_t;

  typedef struct packed {
    logic [MAX_XLEN-1:0]  data;
    logic [MAX_TAG_W-1:0] tag;
  } muldiv_resp_t;

endpackage

// File: rtl/multicycle_muldiv_unit_if.sv
// Request/response handshake bundle between the execute stage (master) and
// the mul/div unit (slave).
interface multicycle_muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/multicycle_muldiv_unit_step.sv
// Combinational UNROLL-deep chain of radix-2 steps on unsigned magnitudes:
// shift-add multiply or restoring divide over a shared {hi, lo} accumulator.
module muldiv_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic [2*XLEN-1:0] acc_o
);

  // Multiply: {hi, lo} = {partial product, remaining multiplier bits}.
  // Divide:   {hi, lo} = {partial remainder, dividend shifting into quotient}.
  function automatic logic [2*XLEN-1:0] step1(input logic div,
                                              input logic [2*XLEN-1:0] acc,
                                              input logic [XLEN-1:0] b);
    logic [XLEN:0]     t;
    logic [2*XLEN-1:0] r;
    if (div) begin
      t = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      if (t >= {1'b0, b}) r = {t[XLEN-1:0] - b, acc[XLEN-2:0], 1'b1};
      else                r = {t[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      t = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b : {XLEN{1'b0}})};
      r = {t, acc[XLEN-1:1]};
    end
    return r;
  endfunction

  logic [UNROLL:0][2*XLEN-1:0] chain;

  assign chain[0] = acc_i;
  for (genvar i = 0; i < UNROLL; i++) begin : g_stage
    assign chain[i+1] = step1(is_div, chain[i], opb_i);
  end
  assign acc_o = chain[UNROLL];

endmodule

// File: rtl/multicycle_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: IDLE accepts an op, CALC iterates
// on magnitudes, FIX applies signs and selects the half, DONE holds the result.
module multicycle_muldiv_unit
  import multicycle_muldiv_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  output logic                     busy,
  multicycle_muldiv_unit_if.slave  bus
);

  if ((XLEN % UNROLL) != 0 || (XLEN != 32 && XLEN != 64)) begin : g_param_chk
    $error("multicycle_muldiv_unit: XLEN must be 32/64 and divisible by UNROLL");
  end

  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d, in_op;
  logic [TAG_W-1:0]  tag_q, tag_d, rtag_q, rtag_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   opb_q, opb_d, data_q, data_d;
  logic [XLEN-1:0]   mag1, mag2, fast_data, fix_data, qr_sel;
  logic              neg_q, neg_d, s1, s2, div0, ovf, accept;
  logic [CW-1:0]     cnt_q, cnt_d;

  assign in_op = muldiv_op_e'(bus.req_op);

  // Operand decode: sign flags, magnitudes and the single-cycle corner cases.
  always_comb begin
    s1     = bus.req_rs1[XLEN-1] & (in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    s2     = bus.req_rs2[XLEN-1] & (in_op inside {OP_MULH, OP_DIV, OP_REM});
    mag1   = s1 ? -bus.req_rs1 : bus.req_rs1;
    mag2   = s2 ? -bus.req_rs2 : bus.req_rs2;
    div0   = in_op[2] & (bus.req_rs2 == '0);
    ovf    = (in_op inside {OP_DIV, OP_REM}) &
             (bus.req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.req_rs2);
    if (div0) fast_data = in_op[1] ? bus.req_rs1 : '1;
    else      fast_data = in_op[1] ? '0 : bus.req_rs1;
    accept = bus.req_valid & ~flush;
  end

  muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .opb_i  (opb_q),
    .acc_o  (acc_step)
  );

  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    qr_sel = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (!op_q[2]) fix_data = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else          fix_data = neg_q ? -qr_sel : qr_sel;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rtag_d  = rtag_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        op_d  = in_op;
        tag_d = bus.req_tag;
        acc_d = {{XLEN{1'b0}}, mag1};
        opb_d = mag2;
        cnt_d = '0;
        // Remainder follows the dividend; product and quotient follow s1^s2.
        neg_d = (in_op[2] & in_op[1]) ? s1 : (s1 ^ s2);
        if (div0 || ovf) begin
          data_d  = fast_data;
          rtag_d  = bus.req_tag;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        data_d  = fix_data;
        rtag_d  = tag_q;
        state_d = ST_DONE;
      end
      ST_DONE: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State advances on the falling edge, in step with the execute pipeline register.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      tag_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rtag_q  <= rtag_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_DONE);
  assign bus.resp_data  = data_q;
  assign bus.resp_tag   = rtag_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multicycle_muldiv_unit.sv
// Scoreboard bench: two units (RV32 radix-2, RV64 unrolled x4) driven with
// directed vectors; a monitor checks every presented response against the queue.
module tb_multicycle_muldiv_unit;
  import multicycle_muldiv_unit_pkg::*;

  localparam int LAT_A = 34;
  localparam int LAT_B = 18;

  logic clk = 1'b0;
  logic rst;
  logic flush_a, flush_b, busy_a, busy_b;

  always #5 clk = ~clk;

  multicycle_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) ifa ();
  multicycle_muldiv_unit_if #(.XLEN(64), .TAG_W(5)) ifb ();

  multicycle_muldiv_unit #(.XLEN(32), .UNROLL(1), .TAG_W(5)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .busy(busy_a), .bus(ifa));
  multicycle_muldiv_unit #(.XLEN(64), .UNROLL(4), .TAG_W(5)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .busy(busy_b), .bus(ifb));

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int          acc_edge;
    int          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   seen [2];

  always @(negedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int s, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h required %h", name, s, act, exp);
    end
  endtask

  // Monitor: samples on the rising edge, away from the DUT's falling edge.
  always @(posedge clk) begin : mon
    logic v, r, rr, bz;
    logic [63:0] d;
    logic [4:0] t;
    exp_t e;
    int sz;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        v = ifa.resp_valid; r = ifa.resp_ready; rr = ifa.req_ready; bz = busy_a;
        d = {32'h0, ifa.resp_data}; t = ifa.resp_tag; sz = qa.size();
        if (sz > 0) e = qa[0];
      end else begin
        v = ifb.resp_valid; r = ifb.resp_ready; rr = ifb.req_ready; bz = busy_b;
        d = ifb.resp_data; t = ifb.resp_tag; sz = qb.size();
        if (sz > 0) e = qb[0];
      end
      if (v && sz == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp dut%0d: got resp_valid=1 data %h, required no response", s, d);
      end else if (v) begin
        if (!seen[s]) begin
          chk("latency", s, 64'(edge_cnt - e.acc_edge + 1), 64'(e.lat));
          seen[s] = 1'b1;
        end
        chk("resp_data", s, d, e.data);
        chk("resp_tag", s, 64'(t), 64'(e.tag));
        chk("req_ready_in_done", s, 64'(rr), 64'(0));
        chk("busy_in_done", s, 64'(bz), 64'(1));
        if (r) begin
          if (s == 0) void'(qa.pop_front());
          else        void'(qb.pop_front());
          seen[s] = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int s, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, input logic [63:0] exp, input int lat, input bit push);
    int n = 0;
    exp_t e;
    @(posedge clk);
    while (!(s == 0 ? ifa.req_ready : ifb.req_ready) && n < 300) begin
      @(posedge clk); n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL issue_timeout dut%0d: req_ready never rose", s);
      return;
    end
    if (s == 0) begin
      ifa.req_valid = 1'b1; ifa.req_op = op; ifa.req_rs1 = a[31:0]; ifa.req_rs2 = b[31:0]; ifa.req_tag = tag;
    end else begin
      ifb.req_valid = 1'b1; ifb.req_op = op; ifb.req_rs1 = a; ifb.req_rs2 = b; ifb.req_tag = tag;
    end
    @(negedge clk); #1;
    e.data = exp; e.tag = tag; e.acc_edge = edge_cnt; e.lat = lat;
    if (push) begin
      if (s == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    if (s == 0) ifa.req_valid = 1'b0;
    else        ifb.req_valid = 1'b0;
  endtask

  task automatic vec(input logic [2:0] op, input logic [4:0] tag,
                     input logic [63:0] a32, input logic [63:0] b32, input logic [63:0] e32,
                     input logic [63:0] a64, input logic [63:0] b64, input logic [63:0] e64,
                     input bit fast);
    issue(0, op, a32, b32, tag, e32, fast ? 1 : LAT_A, 1'b1);
    issue(1, op, a64, b64, tag, e64, fast ? 1 : LAT_B, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 600) begin
      @(negedge clk); n++;
    end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending, required 0", qa.size(), qb.size());
    end
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"}, 0, 64'(busy_a), 64'(0));
    chk({name, "_busy"}, 1, 64'(busy_b), 64'(0));
    chk({name, "_req_ready"}, 0, 64'(ifa.req_ready), 64'(1));
    chk({name, "_req_ready"}, 1, 64'(ifb.req_ready), 64'(1));
    chk({name, "_resp_valid"}, 0, 64'(ifa.resp_valid), 64'(0));
    chk({name, "_resp_valid"}, 1, 64'(ifb.resp_valid), 64'(0));
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  initial begin
    int n;
    rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    ifa.req_valid = 1'b0; ifa.req_op = '0; ifa.req_rs1 = '0; ifa.req_rs2 = '0; ifa.req_tag = '0; ifa.resp_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_op = '0; ifb.req_rs1 = '0; ifb.req_rs2 = '0; ifb.req_tag = '0; ifb.resp_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset_data", 0, 64'(ifa.resp_data), 64'(0));
    chk("reset_tag", 1, 64'(ifb.resp_tag), 64'(0));
    @(posedge clk); @(posedge clk); rst = 1'b1;

    //   op         tag   rs1_32         rs2_32         exp_32         rs1_64   rs2_64         exp_64                 fast
    vec(OP_MUL,    5'd1, 64'h7,         64'hFFFFFFFD,  64'hFFFFFFEB,  64'h7,   ONES-64'd2,    ONES-64'd20,           1'b0);
    vec(OP_MUL,    5'd2, 64'h12345678,  64'h10,        64'h23456780,  64'h12345678, 64'h10,   64'h1_2345_6780,       1'b0);
    vec(OP_MULHU,  5'd3, 64'hFFFFFFFF,  64'hFFFFFFFF,  64'hFFFFFFFE,  ONES,    ONES,          ONES-64'd1,            1'b0);
    vec(OP_MULH,   5'd4, 64'hFFFFFFFF,  64'hFFFFFFFF,  64'h0,         ONES,    ONES,          64'h0,                 1'b0);
    vec(OP_MULHSU, 5'd5, 64'hFFFFFFFF,  64'h2,         64'hFFFFFFFF,  ONES,    64'h2,         ONES,                  1'b0);
    vec(OP_MULHSU, 5'd6, 64'hFFFFFFFF,  64'h80000000,  64'hFFFFFFFF,  ONES,    MIN64,         ONES,                  1'b0);
    vec(OP_MULH,   5'd7, 64'h80000000,  64'h80000000,  64'h40000000,  MIN64,   MIN64,         64'h4000_0000_0000_0000, 1'b0);
    vec(OP_DIV,    5'd8, 64'hFFFFFFF9,  64'h2,         64'hFFFFFFFD,  ONES-64'd6, 64'h2,      ONES-64'd2,            1'b0);
    vec(OP_REM,    5'd9, 64'hFFFFFFF9,  64'h2,         64'hFFFFFFFF,  ONES-64'd6, 64'h2,      ONES,                  1'b0);
    vec(OP_DIV,   5'd10, 64'h7,         64'hFFFFFFFE,  64'hFFFFFFFD,  64'h7,   ONES-64'd1,    ONES-64'd2,            1'b0);
    vec(OP_REM,   5'd11, 64'h7,         64'hFFFFFFFE,  64'h1,         64'h7,   ONES-64'd1,    64'h1,                 1'b0);
    vec(OP_DIVU,  5'd12, 64'd100,       64'd7,         64'd14,        64'd100, 64'd7,         64'd14,                1'b0);
    vec(OP_REMU,  5'd13, 64'd100,       64'd7,         64'd2,         64'd100, 64'd7,         64'd2,                 1'b0);
    vec(OP_DIVU,  5'd14, 64'd5,         64'd0,         64'hFFFFFFFF,  64'd5,   64'd0,         ONES,                  1'b1);
    vec(OP_REMU,  5'd15, 64'd5,         64'd0,         64'd5,         64'd5,   64'd0,         64'd5,                 1'b1);
    vec(OP_DIV,   5'd16, 64'h80000000,  64'hFFFFFFFF,  64'h80000000,  MIN64,   ONES,          MIN64,                 1'b1);
    vec(OP_REM,   5'd17, 64'h80000000,  64'hFFFFFFFF,  64'h0,         MIN64,   ONES,          64'h0,                 1'b1);
    vec(OP_REM,   5'd18, 64'hFFFFFFF9,  64'h0,         64'hFFFFFFF9,  ONES-64'd6, 64'd0,      ONES-64'd6,            1'b1);
    drain();

    // Backpressure: result held three extra cycles, then released.
    ifa.resp_ready = 1'b0;
    issue(0, OP_MUL, 64'd3, 64'd5, 5'd21, 64'd15, LAT_A, 1'b1);
    n = 0;
    while (!ifa.resp_valid && n < 100) begin @(negedge clk); #1; n++; end
    chk("bp_resp_valid", 0, 64'(ifa.resp_valid), 64'(1));
    repeat (3) begin @(negedge clk); #1; end
    chk("bp_held_valid", 0, 64'(ifa.resp_valid), 64'(1));
    chk("bp_held_data", 0, 64'(ifa.resp_data), 64'd15);
    ifa.resp_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("bp_release_busy", 0, 64'(busy_a), 64'(0));
    chk("bp_release_ready", 0, 64'(ifa.req_ready), 64'(1));
    drain();

    // Flush in CALC at count 10: nothing may come back.
    issue(0, OP_MULHU, ONES, ONES, 5'd22, 64'd0, 0, 1'b0);
    issue(1, OP_MULHU, ONES, ONES, 5'd22, 64'd0, 0, 1'b0);
    @(negedge clk); #1;
    repeat (8) begin @(negedge clk); #1; end
    flush_a = 1'b1; flush_b = 1'b1;
    @(negedge clk); #1;
    flush_a = 1'b0; flush_b = 1'b0;
    chk_idle("flush_calc");
    repeat (40) @(negedge clk);
    #1;

    // Flush together with an offered fast-path op in IDLE: op dropped.
    @(posedge clk);
    ifa.req_valid = 1'b1; ifa.req_op = OP_DIVU; ifa.req_rs1 = 32'd5; ifa.req_rs2 = 32'd0; ifa.req_tag = 5'd23;
    ifb.req_valid = 1'b1; ifb.req_op = OP_DIVU; ifb.req_rs1 = 64'd5; ifb.req_rs2 = 64'd0; ifb.req_tag = 5'd23;
    flush_a = 1'b1; flush_b = 1'b1;
    @(negedge clk); #1;
    ifa.req_valid = 1'b0; ifb.req_valid = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
    chk_idle("flush_idle");
    repeat (5) @(negedge clk);
    #1;

    // Asynchronous reset mid-CALC: outputs drop to reset values at once.
    issue(0, OP_DIVU, 64'd100, 64'd7, 5'd24, 64'd0, 0, 1'b0);
    issue(1, OP_DIVU, 64'd100, 64'd7, 5'd24, 64'd0, 0, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid_data", 0, 64'(ifa.resp_data), 64'(0));
    chk("rst_mid_data", 1, ifb.resp_data, 64'(0));
    chk("rst_mid_tag", 0, 64'(ifa.resp_tag), 64'(0));
    chk("rst_mid_tag", 1, 64'(ifb.resp_tag), 64'(0));
    @(posedge clk); rst = 1'b1;
    repeat (40) @(negedge clk);

    // Recovery after reset.
    vec(OP_MUL, 5'd25, 64'd6, 64'd7, 64'd42, 64'd6, 64'd7, 64'd42, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_muldiv_unit.md
Name: multicycle_muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execution unit, parametrised in XLEN and bits-per-iteration.
- Sits beside the single-cycle integer ALU in the execute stage and handles the M-extension ops, which the ALU path cannot complete in one cycle.
- Accepts one op via valid/ready, computes over multiple cycles, and holds the result until the writeback side takes it.
- Drives a busy/stall signal to the pipeline controller; supports flush on branch mispredict.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- UNROLL, 1, radix-2 iterations per cycle; must divide XLEN (elaboration-time assertion).
- TAG_W, 5, width of the destination-register tag carried with each op.

Ports:
- clk  in  1  clock; all state updates on the falling edge, same as the execute pipeline register.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  kills any in-flight or pending op.
- req_valid  in  1  op offered.
- req_ready  out  1  unit can accept an op.
- req_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_rs1  in  XLEN  bypassed operand 1.
- req_rs2  in  XLEN  bypassed operand 2.
- req_tag  in  TAG_W  rd address.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  XLEN  result.
- resp_tag  out  TAG_W  rd of the result.
- busy  out  1  state != IDLE; controller stalls younger ops.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_tag=0, busy=0.
  - Internal accumulators and counter are cleared.
  - Reset mid-operation discards the op; no response is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1 and flush=0, latch op, tag, operand magnitudes and sign flags.
  - Fast path goes straight to DONE (1-cycle latency):
    - divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1.
    - signed overflow (rs1 = most-negative value, rs2 = -1): DIV result = rs1; REM result = 0.
  - Otherwise go to CALC with count=0.
- CALC:
  - Each edge performs UNROLL shift-add multiply steps, or UNROLL restoring-divide steps, on unsigned magnitudes.
  - Multiply keeps a 2*XLEN product register.
  - After XLEN/UNROLL edges, go to FIX.
- FIX (one edge):
  - Apply sign correction. Product is negated if the operand signs differ for the signed variants; MULHSU treats rs2 as unsigned.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
  - Select the low XLEN bits for MUL and the high XLEN bits for the MULH* ops.
  - Register resp_data and resp_tag, then go to DONE.
- Normal latency: a response is visible after acceptance edge N + XLEN/UNROLL + 2 (34 edges for 32/1).
- DONE:
  - resp_valid=1; resp_data and resp_tag are held stable while resp_ready=0.
  - On an edge with resp_ready=1, go to IDLE.
  - req_ready=0, so no same-cycle re-accept.
- flush=1:
  - Next edge: state=IDLE and resp_valid=0, from any state.
  - Flush wins over a simultaneous req_valid (op dropped) and over a simultaneous resp_ready.
- busy = (state != IDLE). Combinational from state; no other output is combinational from inputs.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package (PipelineTypes):
  - MulDivOp enum (the 8 codes above).
  - MulDivState enum.
  - MulDivReq struct {op, rs1, rs2, tag}.
  - MulDivResp struct {data, tag}.
- One sub-module, muldiv_step: combinational UNROLL-deep chain of shift-add/subtract-restore steps, parametrised by XLEN and UNROLL.
- FSM, sign handling and handshake stay in the top module.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (XLEN=32, UNROLL=1) -> resp_data=0xFFFFFFEB, resp_valid rises after edge 34, tag echoed.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each with resp_valid after edge 1.
- Backpressure: resp_ready=0 for 3 cycles in DONE -> resp_data/tag stable, req_ready=0, busy=1; resp_ready=1 -> IDLE next edge.
- flush at CALC count=10, and a separate case with flush together with req_valid in IDLE -> IDLE, no resp_valid ever. Repeat with rst pulsed low mid-CALC -> all outputs at reset values immediately. Rerun the arithmetic cases with XLEN=64, UNROLL=4 (latency 18 edges).
